ascon_perm_arbiter: RTL and testbench

Round-robin arbiter that shares one Ascon `Permutation` core between two requesters, e.g. the hash engine and the AEAD engine. It captures each job's 320-bit state and round count and sequences the core's start/done handshake. It also returns the permuted state with a one-cycle completion pulse and guards against a hung core with a watchdog. It sits between the mode controllers and the single `Permutation` + `RoundCounter` instance.

---
 rtl/ascon_perm_arbiter.sv | 100 ++++++++++
 tb/tb_ascon_perm_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_arbiter.sv
// ascon_perm_arbiter: round-robin sharing of one Ascon permutation core between two clients,
// with job capture, start/done sequencing, rounds check and a hung-core watchdog.
module ascon_perm_arbiter #(
    parameter int MAX_ROUNDS = 12,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [319:0] s_in0,
    input  logic [319:0] s_in1,
    input  logic [4:0]   rounds0,
    input  logic [4:0]   rounds1,
    output logic         ack0,
    output logic         ack1,
    output logic         done0,
    output logic         done1,
    output logic         err,
    output logic [319:0] s_out,
    output logic         p_start,
    output logic [319:0] p_state,
    output logic [4:0]   p_rounds,
    input  logic [319:0] p_out,
    input  logic         p_done
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

    state_t         state;
    logic           owner, last, pend, sel, legal;
    logic [319:0]   st_q;
    logic [4:0]     rnd_q, rnd_sel;
    logic [WW-1:0]  wd;

    assign sel      = (req0 && req1) ? ~last : req1;
    assign rnd_sel  = sel ? rounds1 : rounds0;
    assign legal    = rnd_sel != 5'd0 && rnd_sel <= MAX_R;
    assign p_start  = state == RUN;
    assign p_state  = p_start ? st_q : '0;
    assign p_rounds = p_start ? rnd_q : '0;

    // A rejected job parks in RESP for one extra cycle so its done trails ack by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            pend  <= 1'b0;
            st_q  <= '0;
            rnd_q <= '0;
            wd    <= '0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            s_out <= '0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    owner <= sel;
                    last  <= sel;
                    st_q  <= sel ? s_in1 : s_in0;
                    rnd_q <= rnd_sel;
                    ack0  <= ~sel;
                    ack1  <= sel;
                    wd    <= '0;
                    state <= legal ? RUN : RESP;
                    pend  <= ~legal;
                end
                RUN: if (p_done || wd == WD_LIMIT) begin
                    if (p_done) s_out <= p_out;
                    err   <= ~p_done;
                    done0 <= ~owner;
                    done1 <= owner;
                    state <= RESP;
                end else begin
                    wd <= wd + 1'b1;
                end
                RESP: if (pend) begin
                    pend  <= 1'b0;
                    err   <= 1'b1;
                    done0 <= ~owner;
                    done1 <= owner;
                end else begin
                    wd    <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// tb_ascon_perm_arbiter: directed table, corner sequences and randomized scoreboard run
// against a behavioural Ascon core model and a transaction-level arbiter model.
module tb_ascon_perm_arbiter;
    localparam int TO = 64;

    logic clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0;
    logic [319:0] s_in0 = '0, s_in1 = '0, s_out, p_state, p_out;
    logic [4:0] rounds0 = '0, rounds1 = '0, p_rounds, cnt;
    logic ack0, ack1, done0, done1, err, p_start, p_done;
    logic hang = 1'b0;
    int vec = 0, bad = 0;
    logic [319:0] m_s = '0;
    bit gap_en = 0, seen_run = 0, prev_ps = 0, started = 0;
    int low_run = 0, rmis = 0;
    logic [4:0] cur_r = '0;

    typedef struct {
        bit cl;
        logic [319:0] st;
        logic [4:0] r;
        bit e_err;
        int e_lat;
    } vec_t;
    vec_t tbl[6];

    ascon_perm_arbiter #(.MAX_ROUNDS(12), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .s_in0(s_in0), .s_in1(s_in1),
        .rounds0(rounds0), .rounds1(rounds1), .ack0(ack0), .ack1(ack1), .done0(done0),
        .done1(done1), .err(err), .s_out(s_out), .p_start(p_start), .p_state(p_state),
        .p_rounds(p_rounds), .p_out(p_out), .p_done(p_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input logic [4:0] r);
        logic [63:0] x[5];
        logic [63:0] t[5];
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64 * k -: 64];
        for (int i = 12 - int'(r); i < 12; i++) begin
            x[2] ^= 64'((15 - i) * 16 + i);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
            for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
            x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
            x[2] ^= ror(x[2], 1) ^ ror(x[2], 6);
            x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
            x[4] ^= ror(x[4], 7) ^ ror(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rnd_state();
        logic [319:0] s;
        for (int k = 0; k < 10; k++) s[32 * k +: 32] = $urandom();
        return s;
    endfunction

    function automatic logic [4:0] rnd_rounds();
        if ($urandom_range(0, 7) == 0) return $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(13, 31));
        return 5'($urandom_range(1, 12));
    endfunction

    // Core model: result appears p_rounds cycles after it first sees start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            p_done <= 1'b0;
            p_out <= '0;
        end else if (!p_start || hang) begin
            cnt <= '0;
            p_done <= 1'b0;
        end else begin
            cnt <= cnt + 5'd1;
            p_done <= cnt == p_rounds - 5'd1;
            if (cnt == p_rounds - 5'd1) p_out <= perm(p_state, p_rounds);
        end
    end

    task automatic chk(input string name, input logic [319:0] a, input logic [319:0] e);
        vec++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, a, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (gap_en && seen_run && p_start && !prev_ps) chk("start_gap_ge2", 320'(low_run >= 2), 320'd1);
        if (p_start) begin
            seen_run = 1;
            started = 1;
            if (p_rounds !== cur_r) rmis++;
        end
        low_run = p_start ? 0 : low_run + 1;
        prev_ps = p_start;
    endtask

    task automatic wait_ev(input bit want_done, output logic [1:0] v, output int n);
        v = '0;
        for (n = 1; n <= 200; n++) begin
            tick();
            if (want_done ? (done0 | done1) : (ack0 | ack1)) begin
                v = want_done ? {done1, done0} : {ack1, ack0};
                return;
            end
        end
        vec++;
        bad++;
        $display("FAIL %s: no event within 200 cycles", want_done ? "done_wait" : "ack_wait");
    endtask

    task automatic run_job(input string tag, input bit cl, input logic [319:0] st, input logic [4:0] r,
                           input bit e_err, input int e_lat, input bit e_start);
        logic [1:0] v;
        int n;
        logic [319:0] exp_s;
        tick();
        if (cl) begin req1 = 1; s_in1 = st; rounds1 = r; end
        else begin req0 = 1; s_in0 = st; rounds0 = r; end
        cur_r = r;
        wait_ev(0, v, n);
        chk({tag, "_ack"}, v, cl ? 2'b10 : 2'b01);
        chk({tag, "_ack_lat"}, n, 1);
        req0 = 0;
        req1 = 0;
        started = 0;
        rmis = 0;
        wait_ev(1, v, n);
        exp_s = e_err ? m_s : perm(st, r);
        chk({tag, "_done"}, v, cl ? 2'b10 : 2'b01);
        chk({tag, "_lat"}, n, e_lat);
        chk({tag, "_err"}, err, e_err);
        chk({tag, "_s_out"}, s_out, exp_s);
        chk({tag, "_started"}, started, e_start);
        chk({tag, "_p_rounds"}, rmis, 0);
        m_s = exp_s;
    endtask

    initial begin
        logic [1:0] v;
        int n;
        logic [319:0] sa, sb;
        bit busy, sel, legal;
        bit e_cl, e_err;
        int free_at, e_at;
        logic [4:0] r;
        logic [319:0] st, e_s;
        bit m_last;
        logic [1:0] exp_ack, exp_done;

        tbl[0] = '{1'b0, {64'h00400c0000000100, 256'h0}, 5'd12, 1'b0, 13};
        tbl[1] = '{1'b1, {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0, 64'hffffffffffffffff, 64'h5a5a5a5aa5a5a5a5}, 5'd6, 1'b0, 7};
        tbl[2] = '{1'b1, {10{32'hdeadbeef}}, 5'd0, 1'b1, 1};
        tbl[3] = '{1'b1, {10{32'hcafef00d}}, 5'd13, 1'b1, 1};
        tbl[4] = '{1'b0, {10{32'h13579bdf}}, 5'd1, 1'b0, 2};
        tbl[5] = '{1'b1, {10{32'h2468ace0}}, 5'd31, 1'b1, 1};

        #1 rst = 0;
        #2;
        chk("rst_handshake", {ack0, ack1, done0, done1, err, p_start}, '0);
        chk("rst_s_out", s_out, '0);
        chk("rst_p_bus", {p_state, p_rounds}, '0);
        @(negedge clk) rst = 1;

        foreach (tbl[i]) run_job($sformatf("tbl%0d", i), tbl[i].cl, tbl[i].st, tbl[i].r,
                                 tbl[i].e_err, tbl[i].e_lat, !tbl[i].e_err);

        // Contention: both requests held; grants must alternate starting with client 0.
        sa = rnd_state();
        sb = rnd_state();
        gap_en = 1;
        seen_run = 0;
        tick();
        req0 = 1; s_in0 = sa; rounds0 = 5'd12;
        req1 = 1; s_in1 = sb; rounds1 = 5'd6;
        for (int g = 0; g < 4; g++) begin
            cur_r = g[0] ? 5'd6 : 5'd12;
            wait_ev(0, v, n);
            chk($sformatf("cont%0d_grant", g), v, g[0] ? 2'b10 : 2'b01);
            wait_ev(1, v, n);
            chk($sformatf("cont%0d_done", g), v, g[0] ? 2'b10 : 2'b01);
            chk($sformatf("cont%0d_err", g), err, 1'b0);
            chk($sformatf("cont%0d_s_out", g), s_out, g[0] ? perm(sb, 5'd6) : perm(sa, 5'd12));
        end
        m_s = perm(sb, 5'd6);
        req0 = 0;
        req1 = 0;
        gap_en = 0;

        hang = 1;
        run_job("wdog", 1'b0, rnd_state(), 5'd12, 1'b1, TO + 1, 1'b1);
        hang = 0;
        run_job("post_wdog", 1'b1, rnd_state(), 5'd5, 1'b0, 6, 1'b1);

        // Reset in the middle of a running job.
        tick();
        req0 = 1; s_in0 = rnd_state(); rounds0 = 5'd12;
        cur_r = 5'd12;
        wait_ev(0, v, n);
        chk("mid_ack", v, 2'b01);
        req0 = 0;
        repeat (5) tick();
        chk("mid_running", p_start, 1'b1);
        #2 rst = 0;
        #1 chk("mid_rst_outputs", {p_start, ack0, ack1, done0, done1, p_rounds}, '0);
        tick();
        chk("mid_rst_held", {p_start, done0, done1, s_out}, '0);
        rst = 1;
        m_s = '0;
        sa = rnd_state();
        req0 = 1; s_in0 = sa; rounds0 = 5'd3;
        req1 = 1; s_in1 = rnd_state(); rounds1 = 5'd4;
        cur_r = 5'd3;
        wait_ev(0, v, n);
        chk("rst_tie_grant", v, 2'b01);
        chk("rst_tie_lat", n, 1);
        req0 = 0;
        req1 = 0;
        wait_ev(1, v, n);
        chk("rst_tie_done", v, 2'b01);
        chk("rst_tie_s_out", s_out, perm(sa, 5'd3));

        // Randomized traffic against a transaction-level model.
        tick();
        rst = 0;
        tick();
        rst = 1;
        m_s = '0;
        m_last = 1;
        busy = 0;
        free_at = 0;
        e_at = 0; e_cl = 0; e_err = 0; e_s = '0;
        for (int cyc = 1; cyc <= 2500; cyc++) begin
            @(negedge clk);
            exp_ack = '0;
            sel = 0;
            if (!busy && cyc >= free_at && (req0 || req1)) begin
                sel = (req0 && req1) ? !m_last : req1;
                exp_ack = sel ? 2'b10 : 2'b01;
            end
            if (exp_ack != 0 || (ack0 | ack1)) chk($sformatf("rnd_ack@%0d", cyc), {ack1, ack0}, exp_ack);
            if (exp_ack != 0) begin
                m_last = sel;
                busy = 1;
                r = sel ? rounds1 : rounds0;
                st = sel ? s_in1 : s_in0;
                legal = r != 0 && r <= 12;
                e_cl = sel;
                e_err = !legal;
                e_at = cyc + (legal ? int'(r) + 1 : 1);
                e_s = legal ? perm(st, r) : m_s;
                if (sel) req1 = 0; else req0 = 0;
            end
            exp_done = (busy && cyc == e_at) ? (e_cl ? 2'b10 : 2'b01) : 2'b00;
            if (exp_done != 0 || (done0 | done1)) chk($sformatf("rnd_done@%0d", cyc), {done1, done0}, exp_done);
            if (exp_done != 0) begin
                chk($sformatf("rnd_err@%0d", cyc), err, e_err);
                chk($sformatf("rnd_s_out@%0d", cyc), s_out, e_s);
                m_s = e_s;
                busy = 0;
                free_at = cyc + 2;
            end
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1; s_in0 = rnd_state(); rounds0 = rnd_rounds();
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; s_in1 = rnd_state(); rounds1 = rnd_rounds();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
